// File: rtl/citadel_pkg.sv
// Shared types and default timing constants for the input-path lockout policy.
package citadel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    FLUSH   = 2'd2,
    BRICKED = 2'd3
  } sched_state_t;

  localparam int CLK_HZ           = 25_000_000;
  localparam int BASE_LOCKOUT_DEF = CLK_HZ;        // one second of lockout
  localparam int MAX_SHIFT_DEF    = 3;
  localparam int DECAY_CYCLES_DEF = 10 * CLK_HZ;
  localparam int MAX_STRIKES_DEF  = 7;
  localparam int CNT_W_DEF        = 28;

  localparam int STRIKE_W = 3;
  localparam int DATA_W   = 8;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter; parks at zero and flags the final count of a lockout.
module lockout_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load of N yields exactly N cycles before the owner leaves on done.
  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/lockout_scheduler.sv
// Attack-response policy: exponential back-off lockouts, strike decay, flush on release, and a permanent brick.
import citadel_pkg::*;

module lockout_scheduler #(
  parameter int BASE_LOCKOUT = BASE_LOCKOUT_DEF,
  parameter int MAX_SHIFT    = MAX_SHIFT_DEF,
  parameter int DECAY_CYCLES = DECAY_CYCLES_DEF,
  parameter int MAX_STRIKES  = MAX_STRIKES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                attack_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                hold_o,
  output logic                flush_o,
  output logic                locked_o,
  output logic                brick_o,
  output logic [STRIKE_W-1:0] strikes_o
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;
  localparam longint LONGEST   = longint'(BASE_LOCKOUT) << MAX_SHIFT;

  generate
    if (LONGEST >= CNT_LIMIT || longint'(DECAY_CYCLES) >= CNT_LIMIT) begin : g_cnt_w_check
      $error("lockout_scheduler: CNT_W too narrow for longest lockout or decay period");
    end
    if (MAX_STRIKES < 2 || MAX_STRIKES > 7) begin : g_strikes_check
      $error("lockout_scheduler: MAX_STRIKES must be within 2..7");
    end
  endgenerate

  localparam logic [STRIKE_W-1:0] SHIFT_CAP   = STRIKE_W'(MAX_SHIFT);
  localparam logic [STRIKE_W:0]   STRIKE_CAP  = (STRIKE_W+1)'(MAX_STRIKES);
  localparam logic [CNT_W-1:0]    DECAY_LAST  = CNT_W'(DECAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]    BASE_CNT    = CNT_W'(BASE_LOCKOUT);

  sched_state_t          state, state_nxt;
  logic [STRIKE_W-1:0]   strikes, strikes_nxt;
  logic [CNT_W-1:0]      decay, decay_nxt;
  logic [DATA_W-1:0]     data_nxt;
  logic [STRIKE_W:0]     strikes_inc;
  logic [STRIKE_W-1:0]   shift_amt;
  logic [CNT_W-1:0]      lockout_len;
  logic                  timer_load;
  logic                  timer_done;

  assign strikes_inc = {1'b0, strikes} + 1'b1;
  assign shift_amt   = (strikes > SHIFT_CAP) ? SHIFT_CAP : strikes;
  assign lockout_len = BASE_CNT << shift_amt;

  lockout_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (lockout_len),
    .done     (timer_done)
  );

  always_comb begin
    state_nxt   = state;
    strikes_nxt = strikes;
    decay_nxt   = decay;
    data_nxt    = data_o;
    timer_load  = 1'b0;
    case (state)
      IDLE: begin
        if (attack_i) begin
          // An attack pre-empts any forgiveness due on the same cycle.
          decay_nxt = '0;
          if (strikes_inc >= STRIKE_CAP) begin
            strikes_nxt = STRIKE_CAP[STRIKE_W-1:0];
            state_nxt   = BRICKED;
            data_nxt    = '0;
          end else begin
            strikes_nxt = strikes_inc[STRIKE_W-1:0];
            timer_load  = 1'b1;
            state_nxt   = LOCKED;
          end
        end else begin
          data_nxt = data_i;
          if (strikes == '0) begin
            decay_nxt = '0;
          end else if (decay == DECAY_LAST) begin
            strikes_nxt = strikes - 1'b1;
            decay_nxt   = '0;
          end else begin
            decay_nxt = decay + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (timer_done) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
        decay_nxt = '0;
      end
      BRICKED: begin
        data_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      strikes  <= '0;
      decay    <= '0;
      data_o   <= '0;
      hold_o   <= 1'b0;
      flush_o  <= 1'b0;
      locked_o <= 1'b0;
      brick_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      strikes  <= strikes_nxt;
      decay    <= decay_nxt;
      data_o   <= data_nxt;
      hold_o   <= (state_nxt != IDLE);
      flush_o  <= (state_nxt == FLUSH);
      locked_o <= (state_nxt != IDLE);
      brick_o  <= (state_nxt == BRICKED);
    end
  end

  assign strikes_o = strikes;

endmodule

// File: tb/tb_lockout_scheduler.sv
// Randomized scoreboard bench for lockout_scheduler against a behavioural policy model.
module tb_lockout_scheduler;

  localparam int BASE = 8;
  localparam int MSH  = 2;
  localparam int DEC  = 32;
  localparam int MSTR = 4;
  localparam int CW   = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       hold;
    logic       flush;
    logic       locked;
    logic       brick;
    logic [2:0] strikes;
  } outs_t;

  typedef struct {
    outs_t o;
    int    phase;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       attack_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       hold_o, flush_o, locked_o, brick_o;
  logic [2:0] strikes_o;

  lockout_scheduler #(
    .BASE_LOCKOUT (BASE),
    .MAX_SHIFT    (MSH),
    .DECAY_CYCLES (DEC),
    .MAX_STRIKES  (MSTR),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .attack_i  (attack_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .hold_o    (hold_o),
    .flush_o   (flush_o),
    .locked_o  (locked_o),
    .brick_o   (brick_o),
    .strikes_o (strikes_o)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   phase    = 0;

  // Policy model: remaining lockout cycles, a pending flush, forgiveness progress.
  int         m_strikes, m_quiet, m_lock_left;
  bit         m_flush, m_brick;
  logic [7:0] m_data;

  task automatic model_reset();
    m_strikes = 0; m_quiet = 0; m_lock_left = 0;
    m_flush = 0; m_brick = 0; m_data = 8'h00;
  endtask

  function automatic bit model_idle();
    return !m_brick && (m_lock_left == 0) && !m_flush;
  endfunction

  task automatic model_step(input logic a, input logic [7:0] d);
    if (m_brick) begin
      m_data = 8'h00;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_flush = 1;
    end else if (m_flush) begin
      m_flush = 0;
      m_quiet = 0;
    end else if (a) begin
      m_quiet = 0;
      if (m_strikes + 1 >= MSTR) begin
        m_brick   = 1;
        m_strikes = MSTR;
        m_data    = 8'h00;
      end else begin
        m_lock_left = BASE * (2 ** ((m_strikes < MSH) ? m_strikes : MSH));
        m_strikes++;
      end
    end else begin
      m_data = d;
      if (m_strikes > 0) begin
        m_quiet++;
        if (m_quiet == DEC) begin
          m_strikes--;
          m_quiet = 0;
        end
      end else begin
        m_quiet = 0;
      end
    end
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.data    = m_data;
    o.hold    = m_brick || (m_lock_left > 0) || m_flush;
    o.flush   = m_flush;
    o.locked  = o.hold;
    o.brick   = m_brick;
    o.strikes = 3'(m_strikes);
    return o;
  endfunction

  // Called at a falling edge: drives one cycle and queues what the next rising edge must produce.
  task automatic run_cycle(input logic a, input logic [7:0] d);
    attack_i = a;
    data_i   = d;
    model_step(a, d);
    exp_q.push_back('{o: model_outs(), phase: phase});
    @(negedge clk);
  endtask

  task automatic do_reset();
    outs_t z;
    z = '0;
    attack_i = 1'b0;
    model_reset();
    exp_q.push_back('{o: z, phase: phase});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle();
    int guard;
    guard = 0;
    while (!model_idle() && guard < 200) begin
      run_cycle(($urandom_range(0, 2) == 0), 8'($urandom));
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL idle_wait phase=%0d: model still busy after %0d cycles, required idle", phase, guard);
    end
  endtask

  task automatic rand_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 8'($urandom));
  endtask

  // Monitor: every rising edge (and any reset assertion) presents a response to score.
  initial begin
    forever begin
      exp_t  e;
      outs_t got;
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{data: data_o, hold: hold_o, flush: flush_o, locked: locked_o,
                brick: brick_o, strikes: strikes_o};
        n_checks++;
        if (got === e.o) begin
          n_pass++;
        end else begin
          $display("FAIL outputs phase=%0d t=%0t: got data=%h hold=%b flush=%b locked=%b brick=%b strikes=%0d, required data=%h hold=%b flush=%b locked=%b brick=%b strikes=%0d",
                   e.phase, $time, got.data, got.hold, got.flush, got.locked, got.brick, got.strikes,
                   e.o.data, e.o.hold, e.o.flush, e.o.locked, e.o.brick, e.o.strikes);
        end
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);

    phase = 1;   // reset values, then plain forwarding
    do_reset();
    run_cycle(1'b0, 8'hA5);
    run_cycle(1'b0, 8'h3C);
    rand_idle(3);

    phase = 2;   // first lockout of BASE cycles with ignored attacks inside
    run_cycle(1'b1, 8'h77);
    run_until_idle();
    rand_idle(2);

    phase = 3;   // second strike, then decay 2 -> 1 -> 0 and stays quiet
    run_cycle(1'b1, 8'h11);
    run_until_idle();
    rand_idle(2 * DEC + 8);

    phase = 4;   // attack lands exactly on the forgiveness cycle
    run_cycle(1'b1, 8'h22);
    run_until_idle();
    rand_idle(DEC - 1);
    run_cycle(1'b1, 8'h33);
    run_until_idle();
    rand_idle(4);

    phase = 5;   // asynchronous reset in the middle of a lockout
    run_cycle(1'b1, 8'h44);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'($urandom));
    do_reset();
    rand_idle(3);

    phase = 6;   // back-to-back escalation to the brick, which then persists
    for (int k = 0; k < MSTR - 1; k++) begin
      run_cycle(1'b1, 8'($urandom));
      run_until_idle();
    end
    run_cycle(1'b1, 8'h5A);
    for (int i = 0; i < 1000; i++) run_cycle(($urandom_range(0, 3) == 0), 8'($urandom));
    do_reset();
    rand_idle(2);

    phase = 7;   // random soak
    for (int i = 0; i < 3000; i++) begin
      if (m_brick && $urandom_range(0, 49) == 0) do_reset();
      run_cycle(($urandom_range(0, 11) == 0), 8'($urandom));
    end

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
